// File: rtl/serializer_pkg.sv
// Shared types and helpers for the frame serializer: FSM state encoding,
// parity helper and default frame length.
package serializer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefParityEn = 0;
    localparam int unsigned DefStopBits = 1;

    // Serial bits per frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

    localparam int unsigned FRAME_BITS = frame_bits(DefDataW, DefParityEn, DefStopBits);

    // Callers zero-extend the word; the extra zero bits leave the XOR unchanged.
    function automatic logic calc_parity(input logic [63:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Parallel source / serial transmit bundle of the frame serializer.
interface frame_serializer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              send;
    logic              tx;
    logic              busy;
    logic              hold_full;
    logic              frame_done;
    logic              overrun;

    modport master (
        output data, send,
        input  tx, busy, hold_full, frame_done, overrun
    );

    modport slave (
        input  data, send,
        output tx, busy, hold_full, frame_done, overrun
    );
endinterface

// File: rtl/bit_timer.sv
// Baud counter: free-runs while a frame is active and flags the last cycle of
// every serial bit.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_tick = run && (cnt_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial transmit stage with a one-entry holding register so that
// consecutive frames can be sent without an idle gap.
module frame_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic               clk,
    input logic               rst_n,
    frame_serializer_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic        Odd  = (PARITY_ODD != 0);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              par_q, par_d;
    logic              hold_full_q, hold_full_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic              bit_tick;
    logic              final_edge;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state_q != StIdle),
        .bit_tick(bit_tick)
    );

    assign final_edge = (state_q == StStop) && bit_tick &&
                        (bit_cnt_q == CntW'(STOP_BITS - 1));

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        hold_full_d  = hold_full_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;

        // Mid-frame requests park in the hold slot; the final edge is handled below.
        if (bus.send && (state_q != StIdle) && !final_edge) begin
            if (!hold_full_q) begin
                hold_d      = bus.data;
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.send) begin
                    shift_d = bus.data;
                    par_d   = calc_parity(64'(bus.data), Odd);
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == CntW'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (bit_tick && !final_edge) begin
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end else if (final_edge) begin
                    frame_done_d = 1'b1;
                    if (hold_full_q) begin
                        // Hold drains into the shifter; a same-edge send refills it.
                        shift_d = hold_q;
                        par_d   = calc_parity(64'(hold_q), Odd);
                        tx_d    = 1'b0;
                        state_d = StStart;
                        if (bus.send) begin
                            hold_d = bus.data;
                        end else begin
                            hold_full_d = 1'b0;
                        end
                    end else if (bus.send) begin
                        shift_d = bus.data;
                        par_d   = calc_parity(64'(bus.data), Odd);
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            hold_q       <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            hold_full_q  <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            bit_cnt_q    <= bit_cnt_d;
            par_q        <= par_d;
            hold_full_q  <= hold_full_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.hold_full  = hold_full_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer: four configurations share one clock;
// expected tx bits are queued at send time and popped as the line is sampled.
module tb_frame_serializer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic exp_q[$];
    logic exp_q2[$];

    frame_serializer_if #(.DATA_W(8)) if0 ();
    frame_serializer_if #(.DATA_W(8)) if1 ();
    frame_serializer_if #(.DATA_W(8)) if2 ();
    frame_serializer_if #(.DATA_W(8)) if3 ();

    frame_serializer #(.DATA_W(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    frame_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    frame_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));
    frame_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3));

    always #5 clk = ~clk;

    // Status word {tx, busy, hold_full, frame_done, overrun} of one instance.
    function automatic logic [4:0] st(input int d);
        case (d)
            0:       return {if0.tx, if0.busy, if0.hold_full, if0.frame_done, if0.overrun};
            1:       return {if1.tx, if1.busy, if1.hold_full, if1.frame_done, if1.overrun};
            2:       return {if2.tx, if2.busy, if2.hold_full, if2.frame_done, if2.overrun};
            default: return {if3.tx, if3.busy, if3.hold_full, if3.frame_done, if3.overrun};
        endcase
    endfunction

    // Reference frame, one entry per serial bit, bit 0 sent first.
    function automatic logic [15:0] frame_vec(input logic [7:0] b, input int pe, input int po);
        logic [15:0] v;
        v    = '1;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[1+i] = b[i];
        if (pe != 0) v[9] = (b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7]) ^ (po != 0);
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (st(d) !== 5'b10000) begin
                errors++;
                $display("FAIL reset dut%0d: got %b want %b", d, st(d), 5'b10000);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (st(0) !== 5'b10000) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", st(0), 5'b10000);
        end
    endtask

    task automatic test_basic();
        logic [15:0] fv;
        logic [4:0]  exp;
        logic        etx;
        exp_q.delete();
        fv = frame_vec(8'hA5, 0, 0);
        @(negedge clk);
        if0.data = 8'hA5;
        if0.send = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(fv[i]);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if0.send = 1'b0;
            if0.data = 8'h00;
            etx = 1'b1;
            if (exp_q.size() != 0) etx = exp_q.pop_front();
            exp = {etx, i <= 10, 1'b0, i == 11, 1'b0};
            checks++;
            if (st(0) !== exp) begin
                errors++;
                $display("FAIL basic cycle %0d: got %b want %b", i, st(0), exp);
            end
        end
    endtask

    task automatic test_parity();
        logic [15:0] fe, fo;
        logic [4:0]  e1, e2;
        logic        t1, t2;
        exp_q.delete();
        exp_q2.delete();
        fe = frame_vec(8'h07, 1, 0);
        fo = frame_vec(8'h07, 1, 1);
        @(negedge clk);
        if1.data = 8'h07;
        if1.send = 1'b1;
        if2.data = 8'h07;
        if2.send = 1'b1;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(fe[i]);
            exp_q2.push_back(fo[i]);
        end
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if1.send = 1'b0;
            if2.send = 1'b0;
            t1 = 1'b1;
            t2 = 1'b1;
            if (exp_q.size() != 0) t1 = exp_q.pop_front();
            if (exp_q2.size() != 0) t2 = exp_q2.pop_front();
            e1 = {t1, i <= 11, 1'b0, i == 12, 1'b0};
            e2 = {t2, i <= 11, 1'b0, i == 12, 1'b0};
            checks++;
            if (st(1) !== e1) begin
                errors++;
                $display("FAIL parity_even cycle %0d: got %b want %b", i, st(1), e1);
            end
            checks++;
            if (st(2) !== e2) begin
                errors++;
                $display("FAIL parity_odd cycle %0d: got %b want %b", i, st(2), e2);
            end
        end
    endtask

    task automatic test_spaced();
        logic [15:0] fv;
        logic [7:0]  b;
        logic [4:0]  exp;
        logic        etx;
        exp_q.delete();
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            b  = 8'((k * 37 + 11) & 8'hFF);
            fv = frame_vec(b, 0, 0);
            if0.data = b;
            if0.send = 1'b1;
            for (int i = 0; i < 10; i++) exp_q.push_back(fv[i]);
            exp_q.push_back(1'b1);
            for (int i = 1; i <= 11; i++) begin
                @(negedge clk);
                if0.send = 1'b0;
                etx = 1'b1;
                if (exp_q.size() != 0) etx = exp_q.pop_front();
                exp = {etx, i <= 10, 1'b0, i == 11, 1'b0};
                checks++;
                if (st(0) !== exp) begin
                    errors++;
                    $display("FAIL spaced byte %0d cycle %0d: got %b want %b", k, i, st(0), exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] fa, fb;
        logic [4:0]  exp;
        logic        etx;
        exp_q.delete();
        fa = frame_vec(8'h3C, 0, 0);
        fb = frame_vec(8'hC3, 0, 0);
        for (int i = 0; i < 10; i++) exp_q.push_back(fa[i]);
        for (int i = 0; i < 10; i++) exp_q.push_back(fb[i]);
        @(negedge clk);
        if0.data = 8'h3C;
        if0.send = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            etx = 1'b1;
            if (exp_q.size() != 0) etx = exp_q.pop_front();
            exp = {etx, i <= 20, (i >= 3) && (i <= 10), (i == 11) || (i == 21), i == 4};
            checks++;
            if (st(0) !== exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", i, st(0), exp);
            end
            if0.send = (i == 2) || (i == 3);
            if0.data = (i == 2) ? 8'hC3 : 8'hFF;
        end
        if0.send = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [15:0] fv;
        logic [4:0]  exp;
        logic        etx;
        exp_q.delete();
        @(negedge clk);
        if0.data = 8'h55;
        if0.send = 1'b1;
        @(negedge clk);
        if0.data = 8'h99;
        @(negedge clk);
        if0.send = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (st(0) !== 5'b01100) begin
            errors++;
            $display("FAIL midframe_bit3: got %b want %b", st(0), 5'b01100);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (st(0) !== 5'b10000) begin
            errors++;
            $display("FAIL midframe_async_reset: got %b want %b", st(0), 5'b10000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fv = frame_vec(8'h81, 0, 0);
        if0.data = 8'h81;
        if0.send = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(fv[i]);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if0.send = 1'b0;
            etx = 1'b1;
            if (exp_q.size() != 0) etx = exp_q.pop_front();
            exp = {etx, i <= 10, 1'b0, i == 11, 1'b0};
            checks++;
            if (st(0) !== exp) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got %b want %b", i, st(0), exp);
            end
        end
    endtask

    task automatic test_slow_two_stop();
        logic [15:0] fv;
        logic [4:0]  exp;
        logic        etx;
        exp_q.delete();
        fv = frame_vec(8'h01, 0, 0);
        for (int i = 0; i < 11; i++) repeat (4) exp_q.push_back(fv[i]);
        @(negedge clk);
        if3.data = 8'h01;
        if3.send = 1'b1;
        for (int i = 1; i <= 46; i++) begin
            @(negedge clk);
            if3.send = 1'b0;
            etx = 1'b1;
            if (exp_q.size() != 0) etx = exp_q.pop_front();
            exp = {etx, i <= 44, 1'b0, i == 45, 1'b0};
            checks++;
            if (st(3) !== exp) begin
                errors++;
                $display("FAIL slow cycle %0d: got %b want %b", i, st(3), exp);
            end
        end
    endtask

    initial begin
        if0.data = '0; if0.send = 1'b0;
        if1.data = '0; if1.send = 1'b0;
        if2.data = '0; if2.send = 1'b0;
        if3.data = '0; if3.send = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_spaced();
        test_back_to_back();
        test_reset_midframe();
        test_slow_two_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
Parallel-to-serial transmit stage. Consumes the byte stream driven by the parallel source, where each `data` word is qualified by a one-cycle `send` strobe. Emits an asynchronous-style serial frame on `tx`: start bit, data LSB-first, optional parity, stop bit(s). A one-entry holding register absorbs a byte that arrives while a frame is in flight, so frames can run back-to-back with no idle gap.

Parameters:
DATA_W, 8, data bits per frame
CLKS_PER_BIT, 1, clk cycles per serial bit (>=1)
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data  input  DATA_W  parallel byte, sampled only on edges where send=1
send  input  1  one-cycle strobe: request to transmit data
tx  output  1  serial line, idle high
busy  output  1  frame in progress (shift path occupied)
hold_full  output  1  holding register occupied
frame_done  output  1  one-cycle pulse at end of last stop bit
overrun  output  1  one-cycle pulse: send dropped (shift path and hold both full)

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, hold_full=0, frame_done=0, overrun=0. FSM goes to IDLE; counters and shift register cleared. A frame in progress is aborted; tx returns to 1 immediately, not at the next edge.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit timing: baud counter counts 0..CLKS_PER_BIT-1. Each bit lasts exactly CLKS_PER_BIT cycles.
- IDLE:
  - Edge with send=1: data loads into the shift register; tx<=0; busy<=1; go to START.
  - Latency: tx falls on the same edge that samples send.
- START → DATA after 1 bit time.
- DATA: tx = shift[0]; shift right each bit time; DATA_W bits, bit 0 first. Then go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of the loaded word, XOR PARITY_ODD. Lasts 1 bit time.
- STOP: tx=1 for STOP_BITS bit times.
- Frame length: (2 + DATA_W + PARITY_EN + STOP_BITS - 1) × CLKS_PER_BIT cycles. Defaults give 10 cycles.
- End of last stop bit (same edge): frame_done=1 for 1 cycle. Then:
  - hold_full=1: hold loads into shift, hold_full<=0, tx<=0, go to START. No idle cycle.
  - else, send=1 on this edge: data loads directly into shift, go to START (bypass).
  - else: busy<=0, go to IDLE.
- send=1 while busy, hold_full=0, not the final edge: data goes to hold, hold_full<=1.
- send=1 while busy, hold_full=1, not the final edge: data dropped, overrun=1 for 1 cycle, hold unchanged.
- send=1 on the final edge with hold_full=1: hold moves to shift and new data goes to hold (slot freed same edge). hold_full stays 1; no overrun.
- data is ignored on edges where send=0.
- Parity is computed from the word as loaded, not from the shifting register.

Decomposition:
- Package serializer_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - a parity helper function;
  - localparam FRAME_BITS derived from the parameters.
- One natural sub-module: bit_timer. It holds the baud counter and emits a bit_tick at each bit boundary, which keeps the FSM free of CLKS_PER_BIT logic.

Test Plan:
- Defaults, send 0xA5 once → tx over 10 cycles = 0,1,0,1,0,0,1,0,1,1; busy high for 10 cycles; frame_done pulses on cycle 10; then tx=1 idle.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 → data bits 1,1,1,0,0,0,0,0, parity 1, stop 1 (11 bits). With PARITY_ODD=1 the parity bit = 0.
- Source pattern: 16 bytes, each send followed by 10 idle clocks (11-cycle spacing) → every frame is transmitted intact; hold_full never stays set past 1 frame; overrun never fires.
- Back-to-back: send 0x3C, then 0xC3 on cycle 2, then 0xFF on cycle 3 → 0xC3 is held; 0xFF gives overrun=1 for 1 cycle. The 0xC3 start bit immediately follows the 0x3C stop bit with no idle gap. Total 20 cycles busy.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x55 → tx=1 asynchronously; busy=0 and hold_full=0. After release, a send of 0x81 produces a clean 10-bit frame.
- CLKS_PER_BIT=4, STOP_BITS=2, send 0x01 → each bit held 4 cycles; start is 4 low cycles, then 4 high (bit 0); frame is 44 cycles long.
